// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the two-requester APB arbiter.
package apb_arb_pkg;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 16;

  localparam logic [7:0] SLAVE2_BASE = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;
endpackage

// File: rtl/apb_arbiter_if.sv
// Requester-side handshakes and APB master bus of the arbiter, bundled together.
interface apb_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              req0, req1, wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              done0, done1, err;
  logic [DATA_W-1:0] rdata;
  logic              psel1, psel2, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;
  logic              pready, pslverr;

  modport master (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, prdata, pready, pslverr,
    output done0, done1, rdata, err, psel1, psel2, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, prdata, pready, pslverr,
    input  done0, done1, rdata, err, psel1, psel2, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant with an eligibility mask and a registered last-grant pointer.
module apb_rr_arbiter
  import apb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  logic       i_en,
  output logic [1:0] o_grant
);
  logic [1:0] w_elig;
  logic       r_last;

  assign w_elig = i_req & i_mask;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case (w_elig)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // Pointer starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (o_grant != 2'b00) begin
      r_last <= o_grant[1];
    end
  end
endmodule

// File: rtl/apb_arbiter.sv
// Arbitrates two requesters onto one APB master port with wait-state timeout.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           reset,
  apb_arbiter_if.master bus
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e            r_state;
  logic              r_owner, r_wr, r_done0, r_done1, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [WAIT_W-1:0] r_wait;
  logic [1:0]        w_grant;
  logic              w_idle, w_busy, w_sel2;

  assign w_idle = (r_state == ST_IDLE);
  assign w_busy = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign w_sel2 = (r_addr >= ADDR_W'(SLAVE2_BASE));

  // A requester being told done this cycle still shows req; mask it out.
  apb_rr_arbiter u_rr (
    .clk    (clk),
    .reset  (reset),
    .i_req  ({bus.req1, bus.req0}),
    .i_mask ({~r_done1, ~r_done0}),
    .i_en   (w_idle),
    .o_grant(w_grant)
  );

  always_ff @(posedge clk) begin
    if (w_idle && (w_grant != 2'b00)) begin
      r_owner <= w_grant[1];
      r_wr    <= w_grant[1] ? bus.wr1    : bus.wr0;
      r_addr  <= w_grant[1] ? bus.addr1  : bus.addr0;
      r_wdata <= w_grant[1] ? bus.wdata1 : bus.wdata0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant != 2'b00) r_state <= ST_SETUP;
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_wait  <= '0;
        end
        ST_ACCESS: begin
          if (bus.pready) begin
            r_state <= ST_IDLE;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_rdata <= r_wr ? '0 : bus.prdata;
            r_err   <= bus.pslverr;
            r_wait  <= '0;
          end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
            r_state <= ST_IDLE;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_err   <= 1'b1;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus outputs are decoded from state so they drop the cycle after any exit.
  assign bus.psel1   = w_busy & ~w_sel2;
  assign bus.psel2   = w_busy & w_sel2;
  assign bus.penable = (r_state == ST_ACCESS);
  assign bus.pwrite  = w_busy & r_wr;
  assign bus.paddr   = w_busy ? r_addr  : '0;
  assign bus.pwdata  = w_busy ? r_wdata : '0;
  assign bus.done0   = r_done0;
  assign bus.done1   = r_done1;
  assign bus.rdata   = r_rdata;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_apb_arbiter.sv
// Scoreboard bench: requester drivers push expected responses, a monitor checks grants and completions.
module tb_apb_arbiter;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  apb_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus();

  apb_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Slave behaviour is a pure function of the address.
  function automatic int f_waits(input logic [7:0] a);
    return int'(a[1:0]);
  endfunction
  function automatic logic f_stuck(input logic [7:0] a);
    return (a[6:2] == 5'h1F);
  endfunction
  function automatic logic f_perr(input logic [7:0] a);
    return a[5] & ~a[4];
  endfunction
  function automatic logic [7:0] f_data(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'hC3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_req(input int k, input logic v);
    if (k == 0) bus.req0 = v;
    else        bus.req1 = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input int k, input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    int   n;
    logic seen;
    e.err   = f_stuck(a) | f_perr(a);
    e.rdata = (f_stuck(a) || w) ? 8'h00 : f_data(a);
    e.lat   = f_stuck(a) ? TIMEOUT + 1 : f_waits(a) + 2;
    if (k == 0) begin
      exp_q0.push_back(e);
      bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
    end else begin
      exp_q1.push_back(e);
      bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
    end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      step();
      n++;
      seen = (k == 0) ? bus.done0 : bus.done1;
    end
    if (!seen) chk("done_wait_bound", n, 300 + 1);
  endtask

  task automatic rand_run(input int k, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom);
      if ($urandom_range(0, 9) == 0) a[6:2] = 5'h1F;
      do_txn(k, 1'($urandom), a, 8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        set_req(k, 1'b0);
        repeat ($urandom_range(0, 3)) step();
      end
    end
    set_req(k, 1'b0);
  endtask

  initial begin
    int acc_cnt;
    acc_cnt = 0;
    bus.pready = 1'b0; bus.prdata = 8'h00; bus.pslverr = 1'b0;
    forever begin
      step();
      if ((bus.psel1 | bus.psel2) && bus.penable) begin
        if (!f_stuck(bus.paddr) && acc_cnt == f_waits(bus.paddr)) begin
          bus.pready = 1'b1; bus.prdata = f_data(bus.paddr); bus.pslverr = f_perr(bus.paddr);
        end else begin
          bus.pready = 1'b0; bus.prdata = 8'($urandom); bus.pslverr = 1'b1;
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        bus.pready = 1'($urandom); bus.prdata = 8'($urandom); bus.pslverr = 1'($urandom);
      end
    end
  end

  // Reference: round-robin over eligible requests seen in the previous cycle.
  logic [1:0] snap_req = 2'b00, snap_done = 2'b00;
  logic       snap_idle = 1'b1, snap_rst = 1'b1;
  logic       rr_last = 1'b1, busy = 1'b0, cur_g = 1'b0;
  int         setup_cyc = 0;
  logic [7:0] s_addr, s_wdata;
  logic       s_wr;
  logic [1:0] s_sel;

  always @(negedge clk) begin
    logic       setup_now, access_now, exp_setup, g;
    logic [1:0] elig;
    int         qsize;
    exp_t       e;
    if (mon_en) begin
      setup_now  = (bus.psel1 | bus.psel2) & ~bus.penable;
      access_now = (bus.psel1 | bus.psel2) & bus.penable;
      elig       = snap_req & ~snap_done;
      exp_setup  = snap_idle & ~snap_rst & (elig != 2'b00);
      if (setup_now | exp_setup) chk("grant_setup", setup_now, exp_setup);
      if (setup_now && exp_setup) begin
        g       = (elig == 2'b11) ? ~rr_last : elig[1];
        rr_last = g;
        s_addr  = g ? bus.addr1  : bus.addr0;
        s_wr    = g ? bus.wr1    : bus.wr0;
        s_wdata = g ? bus.wdata1 : bus.wdata0;
        s_sel   = (s_addr >= 8'h80) ? 2'b10 : 2'b01;
        chk("setup_fields", {bus.psel2, bus.psel1, bus.pwrite, bus.paddr, bus.pwdata},
            {s_sel, s_wr, s_addr, s_wdata});
        busy = 1'b1; cur_g = g; setup_cyc = cyc;
      end
      if (access_now) begin
        chk("access_owner", busy, 1'b1);
        chk("access_hold", {bus.psel2, bus.psel1, bus.pwrite, bus.paddr, bus.pwdata},
            {s_sel, s_wr, s_addr, s_wdata});
      end
      if (bus.done0 | bus.done1) begin
        chk("done_onehot", bus.done0 & bus.done1, 1'b0);
        chk("done_bus_quiet", {bus.psel1, bus.psel2, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 0);
        chk("done_owner", {busy, bus.done1}, {1'b1, cur_g});
        qsize = bus.done1 ? exp_q1.size() : exp_q0.size();
        chk("sb_nonempty", qsize != 0, 1'b1);
        if (qsize != 0) begin
          e = bus.done1 ? exp_q1.pop_front() : exp_q0.pop_front();
          chk("rdata", bus.rdata, e.rdata);
          chk("err", bus.err, e.err);
          chk("latency", cyc - setup_cyc, e.lat);
        end
        busy = 1'b0;
      end
    end
    cyc++;
    if (reset) begin
      busy = 1'b0;
      rr_last = 1'b1;
    end
    snap_req  = {bus.req1, bus.req0};
    snap_done = {bus.done1, bus.done0};
    snap_idle = ~busy;
    snap_rst  = reset;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic seen;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    repeat (3) step();
    chk("reset_outputs", {bus.done0, bus.done1, bus.rdata, bus.err, bus.psel1, bus.psel2,
        bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    step();

    do_txn(0, 1'b1, 8'h10, 8'hFF); set_req(0, 1'b0); step();
    do_txn(1, 1'b0, 8'h82, 8'h00); set_req(1, 1'b0); step();

    fork
      begin do_txn(0, 1'b1, 8'h11, 8'hA1); do_txn(0, 1'b0, 8'h93, 8'h00); set_req(0, 1'b0); end
      begin do_txn(1, 1'b0, 8'hC5, 8'h00); do_txn(1, 1'b1, 8'h06, 8'h3C); set_req(1, 1'b0); end
    join
    step();

    do_txn(0, 1'b0, 8'h7C, 8'h00);
    do_txn(0, 1'b0, 8'h20, 8'h00);
    do_txn(0, 1'b0, 8'h01, 8'h00); set_req(0, 1'b0);
    repeat (2) step();

    bus.wr0 = 1'b0; bus.addr0 = 8'h7C; bus.req0 = 1'b1;
    n = 0;
    do begin step(); n++; end while (!bus.penable && n < 10);
    chk("reach_access", bus.penable, 1'b1);
    step();
    reset = 1'b1; bus.req0 = 1'b0;
    step();
    chk("reset_mid_access", {bus.done0, bus.done1, bus.rdata, bus.err, bus.psel1, bus.psel2,
        bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 0);
    step();
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin step(); if (bus.done0 | bus.done1) seen = 1'b1; end
    chk("no_done_after_reset", seen, 1'b0);

    fork
      rand_run(0, 30);
      rand_run(1, 30);
    join
    repeat (5) step();
    chk("sb_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, address width; DATA_W, 8, data width; TIMEOUT, 16, maximum ACCESS cycles before abort.
REQ-002 clk  in  1  single clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0 / req1  in  1  transfer request from requester 0 / 1, level, held until matching done.
REQ-005 wr0 / wr1  in  1  1 = write, 0 = read, for requester 0 / 1.
REQ-006 addr0 / addr1  in  ADDR_W  target address for requester 0 / 1.
REQ-007 wdata0 / wdata1  in  DATA_W  write data for requester 0 / 1.
REQ-008 done0 / done1  out  1  one-cycle completion pulse to requester 0 / 1.
REQ-009 rdata  out  DATA_W  read data, valid while done0 or done1 is high.
REQ-010 err  out  1  error flag (pslverr or timeout), valid while done0 or done1 is high.
REQ-011 psel1 / psel2  out  1  APB select: slave1 when paddr < 8'h80, slave2 when paddr >= 8'h80.
REQ-012 penable, pwrite  out  1  APB enable and direction.
REQ-013 paddr  out  ADDR_W; pwdata  out  DATA_W  APB address and write data.
REQ-014 prdata  in  DATA_W  read data from the selected slave (muxed externally); pready  in  1; pslverr  in  1.

Function
REQ-015 FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-016 IDLE: with any eligible req high, grant one requester, latch its wr/addr/wdata, go SETUP; otherwise stay.
REQ-017 Arbitration SHALL be 2-way round-robin: on a tie, grant the requester not granted last; the pointer updates on every grant.
REQ-018 A requester whose done is high in the current cycle SHALL be ineligible for grant in that cycle.
REQ-019 SETUP: exactly one of psel1/psel2 high (decoded from paddr[7]), penable=0; next state ACCESS unconditionally.
REQ-020 ACCESS: psel held, penable=1; paddr/pwrite/pwdata stable from latched values; requester input changes ignored.
REQ-021 ACCESS with pready=1: capture prdata into rdata (reads; rdata=0 on writes), err=pslverr, go IDLE.
REQ-022 pslverr SHALL be sampled only when pready=1.
REQ-023 A wait counter SHALL count ACCESS cycles with pready=0; after TIMEOUT ACCESS cycles without pready, abort: err=1, rdata=0, go IDLE.
REQ-024 On completion or abort, done0 or done1 (the granted one) SHALL pulse for exactly one cycle, in the cycle after the final ACCESS cycle; all APB outputs are 0 in that cycle.
REQ-025 Latency: req sampled at edge N gives SETUP in cycle N+1, ACCESS in N+2, and with zero wait states done in N+3.
REQ-026 Outside SETUP/ACCESS, psel1, psel2 and penable SHALL be 0; done0 and done1 SHALL never be high together.

Reset
REQ-027 While reset is high at a clock edge: state=IDLE, all outputs 0, wait counter 0, RR pointer set so requester 0 wins the first tie.
REQ-028 Reset during SETUP/ACCESS SHALL abandon the transfer with no done pulse; bus outputs are 0 from the cycle after the reset edge.

Structure
REQ-029 Package apb_arb_pkg SHALL hold the FSM state enum, default ADDR_W/DATA_W/TIMEOUT, and SLAVE2_BASE = 8'h80.
REQ-030 Grant logic SHALL be a sub-module apb_rr_arbiter (2 requests, eligibility mask, registered pointer, one-hot grant).

Verification
REQ-031 Single write: req0, wr0=1, addr0=8'h10, wdata0=8'hFF, pready=1 -> psel1 in SETUP+ACCESS, paddr=8'h10, pwdata=8'hFF, done0 three cycles after req, err=0.
REQ-032 Read with 2 wait states: req1, addr1=8'h80, prdata=8'h5A -> psel2, ACCESS lasts 3 cycles, done1 with rdata=8'h5A.
REQ-033 Simultaneous req0 and req1 held, 4 transfers -> grant order 0,1,0,1; no back-to-back grant to the just-served requester.
REQ-034 pready stuck 0 -> abort after 16 ACCESS cycles, done with err=1, rdata=0; next request proceeds normally.
REQ-035 pslverr=1 with pready=1 on a read of 8'h20 -> done0 with err=1; reset asserted mid-ACCESS -> no done, all outputs 0 the next cycle.
